// File: rtl/r88_regfile_mp_pkg.sv
// Shared encodings for the Rocket88 multi-port register file: pair-op codes and
// external-bus FSM states.
package r88_regfile_mp_pkg;

  typedef enum logic [1:0] {
    R88_PAIR_NOP     = 2'b00,
    R88_PAIR_INC     = 2'b01,
    R88_PAIR_DEC     = 2'b10,
    R88_PAIR_NOP_ALT = 2'b11
  } pairOp_e;

  typedef enum logic [1:0] {
    R88_BUS_IDLE   = 2'd0,
    R88_BUS_ACCESS = 2'd1,
    R88_BUS_DONE   = 2'd2
  } busState_e;

endpackage

// File: rtl/r88_pair_incdec.sv
// Combinational +/-1 on a register pair, modulo 2^W, with zero detect on the result.
module r88_pair_incdec #(
  parameter int W = 16
) (
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic [W-1:0] result,
  output logic         isZero
);

  assign result = dec ? (value - W'(1)) : (value + W'(1));
  assign isZero = (result == '0);

endmodule

// File: rtl/r88_regfile_mp.sv
// Rocket88 register file: two registered read ports, one core write port, pair
// increment/decrement, and a handshaked tri-state external bus access port.
module r88_regfile_mp
  import r88_regfile_mp_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 16,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              sysClock,
  input  logic              sysResetN,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrSel,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdSelA,
  output logic [DATA_W-1:0] rdDataA,
  input  logic [ADDR_W-1:0] rdSelB,
  output logic [DATA_W-1:0] rdDataB,
  input  logic [1:0]        pairOp,
  input  logic [ADDR_W-2:0] pairSel,
  output logic              pairZero,
  output logic              pairClash,
  input  logic              szOutEn,
  output logic              signFlag,
  output logic              zeroFlag,
  inout  wire  [DATA_W-1:0] extD,
  input  logic              busReq,
  input  logic              busWrite,
  input  logic [ADDR_W-1:0] busAddr,
  output logic              busAck
);

  logic [DATA_W-1:0] regFile [NREGS];
  logic [DATA_W-1:0] regNext [NREGS];

  busState_e         busStateReg;
  logic [ADDR_W-1:0] busAddrReg;
  logic              busWriteReg;
  logic [DATA_W-1:0] busDataReg;
  logic              extDOeReg;

  // Pair operation: a core write to either half of the pair cancels it entirely.
  pairOp_e             pairOpE;
  logic                pairActive;
  logic                pairClashNow;
  logic                pairDo;
  logic [2*DATA_W-1:0] pairValue;
  logic [2*DATA_W-1:0] pairResult;
  logic                pairResultZero;

  assign pairOpE      = pairOp_e'(pairOp);
  assign pairActive   = (pairOpE == R88_PAIR_INC) || (pairOpE == R88_PAIR_DEC);
  assign pairClashNow = pairActive && wrEn && (wrSel[ADDR_W-1:1] == pairSel);
  assign pairDo       = pairActive && !pairClashNow;
  assign pairValue    = {regFile[{pairSel, 1'b1}], regFile[{pairSel, 1'b0}]};

  r88_pair_incdec #(
    .W(2*DATA_W)
  ) uPairIncdec (
    .value  (pairValue),
    .dec    (pairOpE == R88_PAIR_DEC),
    .result (pairResult),
    .isZero (pairResultZero)
  );

  // A pending bus write yields to any core or pair write landing on the same register.
  logic busBlocked;
  logic busCommit;

  assign busBlocked = (wrEn && (wrSel == busAddrReg)) ||
                      (pairDo && (busAddrReg[ADDR_W-1:1] == pairSel));
  assign busCommit  = (busStateReg == R88_BUS_ACCESS) && busWriteReg && !busBlocked;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : gReg
      localparam logic [ADDR_W-1:0] Idx = ADDR_W'(gi);

      assign regNext[gi] =
        (wrEn && (wrSel == Idx))                 ? wrData :
        (pairDo && (pairSel == Idx[ADDR_W-1:1])) ? (Idx[0] ? pairResult[2*DATA_W-1:DATA_W]
                                                            : pairResult[DATA_W-1:0]) :
        (busCommit && (busAddrReg == Idx))       ? busDataReg :
                                                   regFile[gi];

      always_ff @(posedge sysClock) begin
        if (!sysResetN) begin
          regFile[gi] <= '0;
        end else begin
          regFile[gi] <= regNext[gi];
        end
      end
    end
  endgenerate

  // Read ports and flags see this cycle's writes (write-first).
  always_ff @(posedge sysClock) begin
    if (!sysResetN) begin
      rdDataA   <= '0;
      rdDataB   <= '0;
      signFlag  <= 1'b0;
      zeroFlag  <= 1'b0;
      pairZero  <= 1'b0;
      pairClash <= 1'b0;
    end else begin
      rdDataA   <= regNext[rdSelA];
      rdDataB   <= regNext[rdSelB];
      pairZero  <= pairDo && pairResultZero;
      pairClash <= pairClashNow;
      if (szOutEn) begin
        signFlag <= regNext[rdSelA][DATA_W-1];
        zeroFlag <= (regNext[rdSelA] == '0);
      end
    end
  end

  always_ff @(posedge sysClock) begin
    if (!sysResetN) begin
      busStateReg <= R88_BUS_IDLE;
      busAddrReg  <= '0;
      busWriteReg <= 1'b0;
      busDataReg  <= '0;
      busAck      <= 1'b0;
      extDOeReg   <= 1'b0;
    end else begin
      busAck    <= 1'b0;
      extDOeReg <= 1'b0;
      case (busStateReg)
        R88_BUS_IDLE: begin
          if (busReq) begin
            busAddrReg  <= busAddr;
            busWriteReg <= busWrite;
            busDataReg  <= extD;
            busStateReg <= R88_BUS_ACCESS;
          end
        end
        R88_BUS_ACCESS: begin
          if (busWriteReg) begin
            if (!busBlocked) begin
              busAck      <= 1'b1;
              busStateReg <= R88_BUS_DONE;
            end
          end else begin
            busDataReg  <= regNext[busAddrReg];
            busAck      <= 1'b1;
            extDOeReg   <= 1'b1;
            busStateReg <= R88_BUS_DONE;
          end
        end
        R88_BUS_DONE: begin
          busStateReg <= R88_BUS_IDLE;
        end
        default: begin
          busStateReg <= R88_BUS_IDLE;
        end
      endcase
    end
  end

  // Released while reset is held so the bus floats before the next edge.
  assign extD = (extDOeReg && sysResetN) ? busDataReg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_r88_regfile_mp.sv
// Directed self-checking bench for r88_regfile_mp: reset, bypass, flags, pair wrap,
// clash, bus read and bus write contention.
module tb_r88_regfile_mp;

  logic       sysClock = 1'b0;
  logic       sysResetN;
  logic       wrEn;
  logic [3:0] wrSel;
  logic [7:0] wrData;
  logic [3:0] rdSelA;
  logic [7:0] rdDataA;
  logic [3:0] rdSelB;
  logic [7:0] rdDataB;
  logic [1:0] pairOp;
  logic [2:0] pairSel;
  logic       pairZero;
  logic       pairClash;
  logic       szOutEn;
  logic       signFlag;
  logic       zeroFlag;
  wire  [7:0] extD;
  logic       busReq;
  logic       busWrite;
  logic [3:0] busAddr;
  logic       busAck;

  logic       tbDrive;
  logic [7:0] tbExtD;

  int checks   = 0;
  int failures = 0;

  assign extD = tbDrive ? tbExtD : 8'bzzzz_zzzz;

  always #5 sysClock = ~sysClock;

  r88_regfile_mp #(
    .DATA_W(8),
    .NREGS (16)
  ) dut (
    .sysClock  (sysClock),
    .sysResetN (sysResetN),
    .wrEn      (wrEn),
    .wrSel     (wrSel),
    .wrData    (wrData),
    .rdSelA    (rdSelA),
    .rdDataA   (rdDataA),
    .rdSelB    (rdSelB),
    .rdDataB   (rdDataB),
    .pairOp    (pairOp),
    .pairSel   (pairSel),
    .pairZero  (pairZero),
    .pairClash (pairClash),
    .szOutEn   (szOutEn),
    .signFlag  (signFlag),
    .zeroFlag  (zeroFlag),
    .extD      (extD),
    .busReq    (busReq),
    .busWrite  (busWrite),
    .busAddr   (busAddr),
    .busAck    (busAck)
  );

  task automatic tick();
    @(posedge sysClock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // A released bus reads back the bench's own pattern; any DUT drive corrupts it.
  task automatic checkHiZ(input string tag);
    tbExtD  = 8'h96;
    tbDrive = 1'b1;
    #1;
    check(tag, extD, 8'h96);
    tbDrive = 1'b0;
  endtask

  task automatic coreWrite(input logic [3:0] sel, input logic [7:0] data);
    wrEn   = 1'b1;
    wrSel  = sel;
    wrData = data;
    tick();
    wrEn   = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sysResetN = 1'b0;
    wrEn = 1'b0; wrSel = '0; wrData = '0;
    rdSelA = '0; rdSelB = '0;
    pairOp = 2'b00; pairSel = '0; szOutEn = 1'b0;
    busReq = 1'b0; busWrite = 1'b0; busAddr = '0;
    tbDrive = 1'b0; tbExtD = '0;
    #2;
    tick();
    sysResetN = 1'b1;

    // Reset clears a preloaded register, outputs and flags
    coreWrite(4'd3, 8'hA5);
    rdSelA = 4'd3;
    tick();
    check("preload_r3", rdDataA, 8'hA5);
    sysResetN = 1'b0;
    tick();
    check("rst_rdA", rdDataA, 8'h00);
    check("rst_busAck", {7'b0, busAck}, 8'h00);
    check("rst_zero", {7'b0, zeroFlag}, 8'h00);
    checkHiZ("rst_extD_hiz");
    sysResetN = 1'b1;
    rdSelB = 4'd3;
    tick();
    check("rst_r3_A", rdDataA, 8'h00);
    check("rst_r3_B", rdDataB, 8'h00);

    // Write-first bypass and flags
    wrEn = 1'b1; wrSel = 4'd5; wrData = 8'h80; rdSelA = 4'd5; szOutEn = 1'b1;
    tick();
    wrEn = 1'b0;
    check("byp_rdA", rdDataA, 8'h80);
    check("byp_sign", {7'b0, signFlag}, 8'h01);
    check("byp_zero", {7'b0, zeroFlag}, 8'h00);
    rdSelA = 4'd0;
    tick();
    check("flag_zero1", {7'b0, zeroFlag}, 8'h01);
    check("flag_sign0", {7'b0, signFlag}, 8'h00);
    szOutEn = 1'b0; rdSelA = 4'd5;
    tick();
    check("hold_rdA", rdDataA, 8'h80);
    check("hold_zero", {7'b0, zeroFlag}, 8'h01);

    // Pair wrap: FFFF+1 -> 0000, 0000-1 -> FFFF, 0001-1 -> 0000
    coreWrite(4'd2, 8'hFF);
    coreWrite(4'd3, 8'hFF);
    pairOp = 2'b01; pairSel = 3'd1;
    tick();
    pairOp = 2'b00;
    check("inc_wrap_pz", {7'b0, pairZero}, 8'h01);
    rdSelA = 4'd2; rdSelB = 4'd3;
    tick();
    check("inc_wrap_lo", rdDataA, 8'h00);
    check("inc_wrap_hi", rdDataB, 8'h00);
    check("pz_pulse_end", {7'b0, pairZero}, 8'h00);
    pairOp = 2'b10;
    tick();
    pairOp = 2'b00;
    check("dec_wrap_lo", rdDataA, 8'hFF);
    check("dec_wrap_hi", rdDataB, 8'hFF);
    check("dec_wrap_pz", {7'b0, pairZero}, 8'h00);
    coreWrite(4'd2, 8'h01);
    coreWrite(4'd3, 8'h00);
    pairOp = 2'b10;
    tick();
    pairOp = 2'b00;
    check("dec_one_pz", {7'b0, pairZero}, 8'h01);
    check("dec_one_lo", rdDataA, 8'h00);

    // Clash: core write to R2 cancels INC of {00,FF}, which would carry into R3
    coreWrite(4'd2, 8'hFF);
    pairOp = 2'b01; pairSel = 3'd1;
    wrEn = 1'b1; wrSel = 4'd2; wrData = 8'h11;
    tick();
    pairOp = 2'b00; wrEn = 1'b0;
    check("clash_flag", {7'b0, pairClash}, 8'h01);
    check("clash_pz", {7'b0, pairZero}, 8'h00);
    check("clash_r2", rdDataA, 8'h11);
    check("clash_r3", rdDataB, 8'h00);
    tick();
    check("clash_end", {7'b0, pairClash}, 8'h00);

    // Bus read: ack and data exactly two edges after request
    coreWrite(4'd7, 8'h3C);
    busReq = 1'b1; busWrite = 1'b0; busAddr = 4'd7;
    tick();
    busReq = 1'b0;
    check("brd_ack_early", {7'b0, busAck}, 8'h00);
    tick();
    check("brd_ack", {7'b0, busAck}, 8'h01);
    check("brd_extD", extD, 8'h3C);
    tick();
    check("brd_ack_end", {7'b0, busAck}, 8'h00);
    checkHiZ("brd_extD_hiz");

    // Bus write loses to a core write in ACCESS, then retries
    busReq = 1'b1; busWrite = 1'b1; busAddr = 4'd4; tbExtD = 8'h55; tbDrive = 1'b1;
    tick();
    busReq = 1'b0; tbDrive = 1'b0;
    wrEn = 1'b1; wrSel = 4'd4; wrData = 8'h22; rdSelA = 4'd4;
    tick();
    wrEn = 1'b0;
    check("bwr_core_r4", rdDataA, 8'h22);
    check("bwr_ack_held", {7'b0, busAck}, 8'h00);
    tick();
    check("bwr_bus_r4", rdDataA, 8'h55);
    check("bwr_ack", {7'b0, busAck}, 8'h01);
    checkHiZ("bwr_extD_hiz");
    tick();
    check("bwr_ack_end", {7'b0, busAck}, 8'h00);

    // Reset in ACCESS aborts the write; FSM then accepts a fresh request
    busReq = 1'b1; busWrite = 1'b1; busAddr = 4'd6; tbExtD = 8'h77; tbDrive = 1'b1;
    tick();
    busReq = 1'b0; tbDrive = 1'b0;
    sysResetN = 1'b0;
    tick();
    sysResetN = 1'b1; rdSelA = 4'd6;
    tick();
    check("abort_ack", {7'b0, busAck}, 8'h00);
    tick();
    check("abort_r6", rdDataA, 8'h00);
    check("abort_ack2", {7'b0, busAck}, 8'h00);
    busReq = 1'b1; busWrite = 1'b1; busAddr = 4'd6; tbExtD = 8'h5A; tbDrive = 1'b1;
    tick();
    busReq = 1'b0; tbDrive = 1'b0;
    tick();
    check("rewr_ack", {7'b0, busAck}, 8'h01);
    check("rewr_r6", rdDataA, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
